// File: rtl/selector_posicion.sv
// selector_posicion: turns pushbuttons, the auto/manual switch and the ambient
// light reading into the registered target-position code P for the blind FSM.
// The chain is: 2-FF synchronisers -> debouncers -> press detectors -> mode FSM.
// A light-zone classifier with hysteresis and dwell filtering runs alongside.
// P codes: 00 bottom, 01 middle, 10 top. The mode FSM state is visible on modo.
module selector_posicion #(
  parameter int DEB_CYCLES   = 50000,
  parameter int DEB_W        = 16,
  parameter int UMBRAL_ALTO  = 180,
  parameter int UMBRAL_BAJO  = 60,
  parameter int HIST         = 10,
  parameter int DWELL_CYCLES = 1000000,
  parameter int DWELL_W      = 24
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       btn_subir,
  input  logic       btn_medio,
  input  logic       btn_bajar,
  input  logic       modo_auto,
  input  logic [7:0] luz,
  output logic [1:0] P,
  output logic [1:0] modo,
  output logic       cambio
);

  // Mode FSM states, also driven out on modo
  localparam logic [1:0] M_MANUAL   = 2'b00;
  localparam logic [1:0] M_AUTO     = 2'b01;
  localparam logic [1:0] M_OVERRIDE = 2'b10;

  // Zone codes equal the position each zone asks for, so the committed zone
  // doubles as the automatic target
  localparam logic [1:0] Z_CLARO  = 2'b00;
  localparam logic [1:0] Z_MEDIO  = 2'b01;
  localparam logic [1:0] Z_OSCURO = 2'b10;

  // Thresholds widened to 9 bits so the hysteresis offsets cannot wrap
  localparam logic [8:0] TH_ALTO_IN  = 9'(UMBRAL_ALTO);
  localparam logic [8:0] TH_BAJO_IN  = 9'(UMBRAL_BAJO);
  localparam logic [8:0] TH_ALTO_OUT = 9'(UMBRAL_ALTO - HIST);
  localparam logic [8:0] TH_BAJO_OUT = 9'(UMBRAL_BAJO + HIST);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  // Bit order for all per-input vectors: 0 subir, 1 medio, 2 bajar, 3 modo_auto
  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_stable;
  logic [3:0]       r_stable_d;
  logic [DEB_W-1:0] r_deb_cnt [4];
  logic [3:0]       w_press;

  logic [8:0]         w_luz9;
  logic [1:0]         w_cand;
  logic [1:0]         r_cand;
  logic [1:0]         r_zona;
  logic [DWELL_W-1:0] r_dwell;

  logic       w_any;
  logic [1:0] w_req;
  logic [1:0] w_modo_next;
  logic [1:0] w_p_next;
  logic [1:0] r_modo;
  logic [1:0] r_p;
  logic       r_cambio;

  assign w_raw   = {modo_auto, btn_bajar, btn_medio, btn_subir};
  assign w_press = r_stable & ~r_stable_d;
  assign w_luz9  = {1'b0, luz};

  // Two-stage synchroniser for the asynchronous raw inputs
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncers: the stable level follows the synced level only after a full
  // run of DEB_CYCLES mismatching samples; any agreement restarts the run
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
      r_stable <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_stable[i]  <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copy of the debounced levels for rising-edge (press) detection
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) r_stable_d <= '0;
    else        r_stable_d <= r_stable;
  end

  // Candidate zone: where the light level would put us given the committed
  // zone; leaving a zone needs the light to cross back past the margin
  always_comb begin
    w_cand = r_zona;
    case (r_zona)
      Z_CLARO: begin
        if (w_luz9 <= TH_BAJO_IN)       w_cand = Z_OSCURO;
        else if (w_luz9 < TH_ALTO_OUT)  w_cand = Z_MEDIO;
      end
      Z_OSCURO: begin
        if (w_luz9 >= TH_ALTO_IN)       w_cand = Z_CLARO;
        else if (w_luz9 > TH_BAJO_OUT)  w_cand = Z_MEDIO;
      end
      default: begin
        if (w_luz9 >= TH_ALTO_IN)       w_cand = Z_CLARO;
        else if (w_luz9 <= TH_BAJO_IN)  w_cand = Z_OSCURO;
        else                            w_cand = Z_MEDIO;
      end
    endcase
  end

  // Dwell filter: commit a new zone only after the same candidate has been
  // seen on DWELL_CYCLES consecutive edges; a changed candidate restarts it
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      r_cand  <= Z_MEDIO;
      r_zona  <= Z_MEDIO;
      r_dwell <= '0;
    end else begin
      r_cand <= w_cand;
      if (w_cand == r_zona) begin
        r_dwell <= '0;
      end else if (w_cand != r_cand) begin
        r_dwell <= DWELL_W'(1);
      end else if (r_dwell == DWELL_LAST) begin
        r_zona  <= w_cand;
        r_dwell <= '0;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  // Button request with downward priority: bajar > medio > subir
  always_comb begin
    w_any = |w_press[2:0];
    if (w_press[2])      w_req = 2'b00;
    else if (w_press[1]) w_req = 2'b01;
    else                 w_req = 2'b10;
  end

  // Mode FSM next state and next position
  always_comb begin
    w_modo_next = r_modo;
    w_p_next    = r_p;
    case (r_modo)
      M_MANUAL: begin
        if (w_press[3]) begin
          w_modo_next = M_AUTO;
          w_p_next    = r_zona;
        end else if (w_any) begin
          w_p_next = w_req;
        end
      end
      M_AUTO: begin
        if (w_any) begin
          w_modo_next = M_OVERRIDE;
          w_p_next    = w_req;
        end else if (!r_stable[3]) begin
          w_modo_next = M_MANUAL;
        end else begin
          w_p_next = r_zona;
        end
      end
      M_OVERRIDE: begin
        if (w_any)        w_p_next    = w_req;
        if (!r_stable[3]) w_modo_next = M_MANUAL;
      end
      default: w_modo_next = M_MANUAL;
    endcase
  end

  // Registered outputs; cambio marks the cycle P first shows a new value
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      r_modo   <= M_MANUAL;
      r_p      <= 2'b00;
      r_cambio <= 1'b0;
    end else begin
      r_modo   <= w_modo_next;
      r_p      <= w_p_next;
      r_cambio <= (w_p_next != r_p);
    end
  end

  assign P      = r_p;
  assign modo   = r_modo;
  assign cambio = r_cambio;

endmodule

// File: tb/tb_selector_posicion.sv
// Testbench for selector_posicion with short debounce/dwell parameters.
// Directed scenarios followed by a randomized run, all checked every cycle
// against a window-based reference model of the command stage.
module tb_selector_posicion;

  localparam int DEB   = 4;
  localparam int DWELL = 8;
  localparam int ALTO  = 180;
  localparam int BAJO  = 60;
  localparam int HIST  = 10;

  logic       reloj = 1'b0;
  logic       reset = 1'b0;
  logic       btn_subir = 1'b0;
  logic       btn_medio = 1'b0;
  logic       btn_bajar = 1'b0;
  logic       modo_auto = 1'b0;
  logic [7:0] luz = 8'd120;
  logic [1:0] P;
  logic [1:0] modo;
  logic       cambio;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] exp_q[$];

  // Clock / reset block
  always #5 reloj = ~reloj;

  selector_posicion #(
    .DEB_CYCLES(DEB), .DEB_W(4), .UMBRAL_ALTO(ALTO), .UMBRAL_BAJO(BAJO),
    .HIST(HIST), .DWELL_CYCLES(DWELL), .DWELL_W(8)
  ) dut (
    .reloj(reloj), .reset(reset), .btn_subir(btn_subir), .btn_medio(btn_medio),
    .btn_bajar(btn_bajar), .modo_auto(modo_auto), .luz(luz),
    .P(P), .modo(modo), .cambio(cambio)
  );

  // Reference model: debounced levels and zones are derived from windows of
  // recent samples rather than counters. Zone value 0 CLARO, 1 MEDIO, 2 OSCURO
  // (equal to the position each zone requests). Mode 0 MANUAL, 1 AUTO, 2 OVERRIDE.
  logic [3:0] m_s1, m_s2, m_stab, m_stab_d;
  logic [3:0] m_win [DEB];
  int         m_cwin [DWELL];
  int         m_zone, m_mode, m_p;
  logic       m_cambio;

  function automatic int cand_of(input int z, input int l);
    if (l >= ALTO) return 0;
    if (l <= BAJO) return 2;
    if (z == 0 && l >= ALTO - HIST) return 0;
    if (z == 2 && l <= BAJO + HIST) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stab = '0; m_stab_d = '0;
    for (int k = 0; k < DEB; k++) m_win[k] = '0;
    for (int k = 0; k < DWELL; k++) m_cwin[k] = 1;
    m_zone = 1; m_mode = 0; m_p = 0; m_cambio = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw, input int l);
    logic [3:0] press, n_stab;
    int c, n_zone, n_mode, n_p, req;
    bit all_diff, all_same, any;
    press = m_stab & ~m_stab_d;
    for (int k = DEB - 1; k > 0; k--) m_win[k] = m_win[k-1];
    m_win[0] = m_s2;
    n_stab = m_stab;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (m_win[k][i] == m_stab[i]) all_diff = 1'b0;
      if (all_diff) n_stab[i] = ~m_stab[i];
    end
    c = cand_of(m_zone, l);
    for (int k = DWELL - 1; k > 0; k--) m_cwin[k] = m_cwin[k-1];
    m_cwin[0] = c;
    all_same = 1'b1;
    for (int k = 0; k < DWELL; k++) if (m_cwin[k] != c) all_same = 1'b0;
    n_zone = (all_same && c != m_zone) ? c : m_zone;
    any = |press[2:0];
    req = press[2] ? 0 : (press[1] ? 1 : 2);
    n_mode = m_mode;
    n_p    = m_p;
    if (m_mode == 0) begin
      if (press[3]) begin n_mode = 1; n_p = m_zone; end
      else if (any) n_p = req;
    end else if (m_mode == 1) begin
      if (any) begin n_mode = 2; n_p = req; end
      else if (!m_stab[3]) n_mode = 0;
      else n_p = m_zone;
    end else begin
      if (any) n_p = req;
      if (!m_stab[3]) n_mode = 0;
    end
    m_cambio = (n_p != m_p);
    m_p      = n_p;
    m_mode   = n_mode;
    m_zone   = n_zone;
    m_stab_d = m_stab;
    m_stab   = n_stab;
    m_s2     = m_s1;
    m_s1     = raw;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs();
    logic [4:0] e;
    logic [1:0] mp, mm;
    e = exp_q.pop_front();
    mp = e[4:3];
    mm = e[2:1];
    chk("model_P", P, mp);
    chk("model_modo", modo, mm);
    chk("model_cambio", {1'b0, cambio}, {1'b0, e[0]});
  endtask

  // Driver: one clock edge, advance the model, then compare #1 later
  task automatic tick();
    logic [1:0] ep, em;
    @(posedge reloj);
    if (!reset) model_reset();
    else model_edge({modo_auto, btn_bajar, btn_medio, btn_subir}, int'(luz));
    ep = m_p[1:0];
    em = m_mode[1:0];
    exp_q.push_back({ep, em, m_cambio});
    #1;
    check_outputs();
  endtask

  int luz_tab [16] = '{0, 30, 60, 61, 70, 71, 100, 120, 165, 169, 170, 171, 179, 180, 200, 255};
  int h_s, h_m, h_b, h_a, h_l, h_r;

  initial begin
    model_reset();
    // Reset state
    repeat (3) tick();
    chk("reset_P", P, 2'b00);
    chk("reset_modo", modo, 2'b00);
    chk("reset_cambio", {1'b0, cambio}, 2'b00);
    reset = 1'b1;

    // Scenario 1: clean press of subir, P changes on edge DEB+3
    btn_subir = 1'b1;
    repeat (6) tick();
    chk("s1_P_edge6", P, 2'b00);
    tick();
    chk("s1_P_edge7", P, 2'b10);
    chk("s1_cambio_on", {1'b0, cambio}, 2'b01);
    chk("s1_modo", modo, 2'b00);
    tick();
    chk("s1_cambio_off", {1'b0, cambio}, 2'b00);
    repeat (12) tick();
    btn_subir = 1'b0;
    repeat (10) tick();

    // Scenario 2: short glitch ignored, then medio, then bajar+subir together
    btn_medio = 1'b1;
    repeat (3) tick();
    btn_medio = 1'b0;
    repeat (10) tick();
    chk("s2_glitch_P", P, 2'b10);
    btn_medio = 1'b1;
    repeat (8) tick();
    btn_medio = 1'b0;
    chk("s2_medio_P", P, 2'b01);
    repeat (10) tick();
    btn_bajar = 1'b1;
    btn_subir = 1'b1;
    repeat (7) tick();
    chk("s2_both_P", P, 2'b00);
    chk("s2_both_cambio", {1'b0, cambio}, 2'b01);
    tick();
    chk("s2_both_cambio_off", {1'b0, cambio}, 2'b00);
    repeat (5) tick();
    btn_bajar = 1'b0;
    btn_subir = 1'b0;
    repeat (10) tick();

    // Scenario 3: AUTO entry, zone dwell, hysteresis
    modo_auto = 1'b1;
    repeat (6) tick();
    chk("s3_modo_before", modo, 2'b00);
    tick();
    chk("s3_modo_auto", modo, 2'b01);
    chk("s3_entry_P", P, 2'b01);
    luz = 8'd200;
    repeat (8) tick();
    chk("s3_dwell_P_hold", P, 2'b01);
    tick();
    chk("s3_claro_P", P, 2'b00);
    luz = 8'd175;
    repeat (20) tick();
    chk("s3_hyst_P", P, 2'b00);
    luz = 8'd165;
    repeat (9) tick();
    chk("s3_medio_P", P, 2'b01);

    // Scenario 4: light toggling faster than the dwell never moves P
    for (int r = 0; r < 5; r++) begin
      luz = 8'd200;
      repeat (4) tick();
      luz = 8'd100;
      repeat (4) tick();
    end
    chk("s4_toggle_P", P, 2'b01);

    // Scenario 5: press in AUTO enters OVERRIDE, auto ignored, exit to MANUAL
    luz = 8'd200;
    repeat (10) tick();
    chk("s5_auto_P", P, 2'b00);
    btn_subir = 1'b1;
    repeat (7) tick();
    chk("s5_override_modo", modo, 2'b10);
    chk("s5_override_P", P, 2'b10);
    repeat (3) tick();
    btn_subir = 1'b0;
    luz = 8'd30;
    repeat (20) tick();
    chk("s5_dark_P", P, 2'b10);
    modo_auto = 1'b0;
    repeat (7) tick();
    chk("s5_manual_modo", modo, 2'b00);
    chk("s5_manual_P", P, 2'b10);

    // Scenario 6: asynchronous reset mid-dwell, then AUTO entry at MEDIO
    luz = 8'd120;
    repeat (3) tick();
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    chk("s6_async_P", P, 2'b00);
    chk("s6_async_modo", modo, 2'b00);
    chk("s6_async_cambio", {1'b0, cambio}, 2'b00);
    repeat (3) tick();
    reset = 1'b1;
    modo_auto = 1'b1;
    repeat (6) tick();
    chk("s6_modo_before", modo, 2'b00);
    tick();
    chk("s6_modo_auto", modo, 2'b01);
    chk("s6_entry_P", P, 2'b01);

    // Randomized run against the model
    h_s = 0; h_m = 0; h_b = 0; h_a = 0; h_l = 0; h_r = 0;
    for (int c = 0; c < 3000; c++) begin
      if (h_s == 0) begin btn_subir = ($urandom_range(0, 3) == 0); h_s = $urandom_range(1, 12); end
      else h_s--;
      if (h_m == 0) begin btn_medio = ($urandom_range(0, 3) == 0); h_m = $urandom_range(1, 12); end
      else h_m--;
      if (h_b == 0) begin btn_bajar = ($urandom_range(0, 4) == 0); h_b = $urandom_range(1, 12); end
      else h_b--;
      if (h_a == 0) begin modo_auto = ($urandom_range(0, 1) == 1); h_a = $urandom_range(1, 80); end
      else h_a--;
      if (h_l == 0) begin
        if ($urandom_range(0, 3) == 0) luz = 8'($urandom_range(0, 255));
        else luz = 8'(luz_tab[$urandom_range(0, 15)]);
        h_l = $urandom_range(1, 14);
      end else h_l--;
      if (!reset) begin
        if (h_r == 0) reset = 1'b1;
        else h_r--;
      end else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        model_reset();
        h_r = $urandom_range(0, 3);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/selector_posicion.md
Name: selector_posicion

Overview:
- Upstream command stage for the blind-control Mealy FSM.
- Turns three raw pushbuttons, an auto/manual switch and an 8-bit ambient-light reading into the registered 2-bit target-position code P consumed by the FSM.
- P encoding: 00 = bottom (Sinf), 01 = middle (Smed), 10 = top (Ssup); 11 is never emitted.
- Contains synchronisers, debouncers, a mode FSM and a light-zone classifier with hysteresis and dwell filtering.

Parameters:
DEB_CYCLES, 50000, stable cycles required before a debounced input changes (>=2)
DEB_W, 16, debounce counter width (2^DEB_W > DEB_CYCLES)
UMBRAL_ALTO, 180, light level entering CLARO zone
UMBRAL_BAJO, 60, light level entering OSCURO zone
HIST, 10, hysteresis margin (UMBRAL_BAJO+HIST < UMBRAL_ALTO-HIST)
DWELL_CYCLES, 1000000, consecutive cycles a new zone must persist before auto acts
DWELL_W, 24, dwell counter width

Ports:
reloj  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
btn_subir  in  1  raw button, active-high, async: request top
btn_medio  in  1  raw button, active-high, async: request middle
btn_bajar  in  1  raw button, active-high, async: request bottom
modo_auto  in  1  raw switch, async: 1 = automatic mode
luz  in  8  ambient light, synchronous to reloj, 0 = dark
P  out  2  target position code to blind FSM
modo  out  2  00 MANUAL, 01 AUTO, 10 OVERRIDE
cambio  out  1  one-cycle pulse, registered with each change of P

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-low. Reset values: P=00, modo=00, cambio=0, all debounced levels 0, counters 0, zone=MEDIO.
- Input conditioning: each of the four raw inputs passes through a 2-FF synchroniser, then a debouncer.
  - Debouncer counts while synced != stable; clears to 0 whenever they match.
  - When count==DEB_CYCLES-1 and still mismatched: stable<=synced, count<=0.
- Press pulse = stable & ~stable_delayed, one cycle per press.
- Button latency: a clean press changes P exactly DEB_CYCLES+3 rising edges after the first edge sampling it high. Glitches shorter than DEB_CYCLES synced cycles are ignored.
- Simultaneous presses in the same cycle: priority bajar > medio > subir (safety: downward wins).
- Mode FSM (on debounced modo_auto, mode_a):
  - MANUAL: press pulse sets P. mode_a rising -> AUTO.
  - AUTO: P follows the zone target. Any press pulse -> OVERRIDE, and P takes the pressed value in the same cycle. mode_a low -> MANUAL.
  - OVERRIDE: presses set P; auto is ignored. mode_a low -> MANUAL (P held). Re-entering AUTO requires mode_a high again.
  - Leaving AUTO never changes P by itself.
- Zone classifier (always running, registered):
  - MEDIO -> CLARO if luz>=UMBRAL_ALTO.
  - MEDIO -> OSCURO if luz<=UMBRAL_BAJO.
  - CLARO -> MEDIO if luz<UMBRAL_ALTO-HIST.
  - OSCURO -> MEDIO if luz>UMBRAL_BAJO+HIST.
  - CLARO <-> OSCURO direct jump allowed when the entry threshold of the other zone is met.
  - Candidate zone must hold DWELL_CYCLES consecutive cycles before the committed zone updates. Any interruption clears the dwell counter.
- Zone target: CLARO -> 00, MEDIO -> 01, OSCURO -> 10.
  - In AUTO, P <= target the cycle after the committed zone changes.
  - On entry to AUTO, P <= current target on the entry cycle.
- Comparisons are unsigned 8-bit. Threshold arithmetic is done at 9 bits, so no wrap.
- cambio: asserted for exactly one cycle, in the same cycle P shows a new value. A request equal to the current P gives no cambio.
- Reset mid-debounce or mid-dwell: all counters clear, outputs return to reset values, and a still-held button is treated as a fresh press after release-free re-qualification.

Test Plan:
All scenarios use DEB_CYCLES=4, DWELL_CYCLES=8, defaults otherwise.
1. Reset, then btn_subir held high 20 cycles in MANUAL -> P 00->10 at edge 7, cambio high 1 cycle, modo=00.
2. btn_medio 3-cycle glitch, then btn_bajar+btn_subir pressed together from P=01 -> glitch ignored; P=00 (bajar wins); cambio one pulse.
3. modo_auto high, luz=200 steady -> modo=01; after zone dwell of 8 cycles, P=00. luz=175 -> no change (hysteresis). luz=165 for 8 cycles -> P=01.
4. AUTO, luz toggling 200/100 every 4 cycles -> P never changes (dwell reset).
5. AUTO with P=00, press btn_subir -> modo=10, P=10. luz=30 for 20 cycles -> P stays 10. modo_auto low -> modo=00, P=10.
6. Assert reset (low) mid-dwell with P=10 -> P=00, modo=00, cambio=0 immediately, without waiting for a clock edge. After release, modo_auto high and luz=120 -> P=01 on AUTO entry.
